// File: rtl/cl_pcim_burst_mstr.sv
// cl_pcim_burst_mstr
//   AXI4 initiator on the CL->shell PCIM port. Each accepted command issues a
//   single INCR burst of 1-16 full-width beats: a write sends the local beat
//   buffer to host memory, a read brings host memory back into the buffer.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_wr/cmd_rd/cmd_addr/    command port, sampled while cmd_ready (IDLE);
//   cmd_len/cmd_id             write wins if both strobes are set
//   cmd_ready, done, err       idle flag, 1-cycle completion pulse, sticky error
//   buf_we/buf_idx/buf_wdata   buffer load port (only honoured in IDLE)
//   buf_rdata                  buf[buf_idx], registered, 1-cycle latency
//   mis_cnt                    read-compare mismatch count
//   aw*/w*/b*/ar*/r*           AXI4 master channels
//
// Build option
//   CL_PCIM_MSTR_RDCMP_EN      read beats are compared against the buffer
//                              instead of stored; mismatches counted in mis_cnt.
//                              Undefined: read beats overwrite the buffer and
//                              mis_cnt stays 0.
module cl_pcim_burst_mstr #(
  parameter int unsigned ID_W   = 16,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 512,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_wr,
  input  logic                     cmd_rd,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [3:0]               cmd_len,
  input  logic [5:0]               cmd_id,
  output logic                     cmd_ready,
  output logic                     done,
  output logic                     err,
  input  logic                     buf_we,
  input  logic [$clog2(DEPTH)-1:0] buf_idx,
  input  logic [DATA_W-1:0]        buf_wdata,
  output logic [DATA_W-1:0]        buf_rdata,
  output logic [4:0]               mis_cnt,
  output logic [ID_W-1:0]          awid,
  output logic [ADDR_W-1:0]        awaddr,
  output logic [7:0]               awlen,
  output logic [2:0]               awsize,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [DATA_W-1:0]        wdata,
  output logic [DATA_W/8-1:0]      wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic [ID_W-1:0]          bid,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready,
  output logic [ID_W-1:0]          arid,
  output logic [ADDR_W-1:0]        araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [ID_W-1:0]          rid,
  input  logic [DATA_W-1:0]        rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_WA, S_WD, S_WB, S_RA, S_RD, S_DONE} state_t;

  state_t              state, nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          len_q;
  logic [5:0]          id_q;
  // One extra bit so the read index can park at DEPTH once the buffer is full.
  logic [IDX_W:0]      beat;
  logic [IDX_W-1:0]    beat_idx;
  logic                beat_in;
  logic                beat_is_last;
  logic [4:0]          mis_q, mis_nxt;
  logic                rd_mis;
  logic                cmd_go, cmd_bad;
  logic [12:0]         span, end_off;
  logic                unused_ok;

  assign unused_ok = ^{bid, rid};

  assign beat_idx     = beat[IDX_W-1:0];
  assign beat_in      = beat < DEPTH_C;
  assign beat_is_last = beat == (IDX_W+1)'(len_q);

  // Burst must start 64B aligned and end at or before the next 4KB page.
  assign span    = ({9'd0, cmd_len} + 13'd1) << 6;
  assign end_off = {1'b0, cmd_addr[11:0]} + span;
  assign cmd_go  = cmd_wr | cmd_rd;
  assign cmd_bad = (cmd_addr[5:0] != 6'd0) || (end_off > 13'd4096);

`ifdef CL_PCIM_MSTR_RDCMP_EN
  localparam bit RD_STORE = 1'b0;
  assign rd_mis = rvalid && beat_in && (rdata != mem[beat_idx]);
`else
  localparam bit RD_STORE = 1'b1;
  assign rd_mis = 1'b0;
`endif

  assign mis_nxt = (rd_mis && mis_q != 5'd16) ? mis_q + 5'd1 : mis_q;
  assign mis_cnt = mis_q;

  assign awid   = ID_W'(id_q);
  assign arid   = ID_W'(id_q);
  assign awaddr = addr_q;
  assign araddr = addr_q;
  assign awlen  = {4'h0, len_q};
  assign arlen  = {4'h0, len_q};
  assign awsize = 3'b110;
  assign arsize = 3'b110;
  assign wstrb  = '1;
  assign wdata  = mem[beat_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt       = state;
    cmd_ready = 1'b0;
    done      = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    wlast     = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_go) nxt = cmd_bad ? S_DONE : (cmd_wr ? S_WA : S_RA);
      end
      S_WA: begin
        awvalid = 1'b1;
        if (awready) nxt = S_WD;
      end
      S_WD: begin
        wvalid = 1'b1;
        wlast  = beat_is_last;
        if (wready && beat_is_last) nxt = S_WB;
      end
      S_WB: begin
        bready = 1'b1;
        if (bvalid) nxt = S_DONE;
      end
      S_RA: begin
        arvalid = 1'b1;
        if (arready) nxt = S_RD;
      end
      S_RD: begin
        rready = 1'b1;
        if (rvalid && rlast) nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        nxt  = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      len_q  <= '0;
      id_q   <= '0;
      beat   <= '0;
      err    <= 1'b0;
      mis_q  <= '0;
    end else begin
      case (state)
        S_IDLE: if (cmd_go) begin
          addr_q <= cmd_addr;
          len_q  <= cmd_len;
          id_q   <= cmd_id;
          beat   <= '0;
          err    <= cmd_bad;
          mis_q  <= '0;
        end
        S_WD: if (wready) beat <= beat + (IDX_W+1)'(1);
        S_WB: if (bvalid && bresp != 2'b00) err <= 1'b1;
        S_RD: if (rvalid) begin
          if (beat_in) beat <= beat + (IDX_W+1)'(1);
          mis_q <= mis_nxt;
          // Compare outcome of the final beat is folded in so err is valid with done.
          err   <= err | (rresp != 2'b00) | (rlast && !beat_is_last) |
                   (rlast && mis_nxt != 5'd0);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && buf_we)
      mem[buf_idx] <= buf_wdata;
    else if (RD_STORE && state == S_RD && rvalid && beat_in)
      mem[beat_idx] <= rdata;
    buf_rdata <= mem[buf_idx];
  end

endmodule

// File: tb/tb_cl_pcim_burst_mstr.sv
// Self-checking bench for cl_pcim_burst_mstr: the bench plays the AXI slave,
// keeps its own copy of the beat buffer and predicts data, err and mis_cnt.
module tb_cl_pcim_burst_mstr;
  localparam int ID_W = 16, ADDR_W = 64, DATA_W = 512, DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              cmd_wr = 0, cmd_rd = 0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [3:0]        cmd_len = '0;
  logic [5:0]        cmd_id = '0;
  logic              cmd_ready, done, err;
  logic              buf_we = 0;
  logic [3:0]        buf_idx = '0;
  logic [DATA_W-1:0] buf_wdata = '0, buf_rdata;
  logic [4:0]        mis_cnt;
  logic [ID_W-1:0]   awid, arid, bid = '0, rid = '0;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [7:0]        awlen, arlen;
  logic [2:0]        awsize, arsize;
  logic              awvalid, awready = 0, wvalid, wready = 0, wlast;
  logic [DATA_W-1:0] wdata, rdata = '0;
  logic [DATA_W/8-1:0] wstrb;
  logic [1:0]        bresp = '0, rresp = '0;
  logic              bvalid = 0, bready, arvalid, arready = 0;
  logic              rlast = 0, rvalid = 0, rready;

  cl_pcim_burst_mstr #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_wr(cmd_wr), .cmd_rd(cmd_rd), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_id(cmd_id), .cmd_ready(cmd_ready), .done(done), .err(err),
    .buf_we(buf_we), .buf_idx(buf_idx), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
    .mis_cnt(mis_cnt),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid),
    .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid),
    .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [DATA_W-1:0] ref_buf [DEPTH];
  logic [DATA_W-1:0] rdat [20];
  logic [1:0]        rrsp [20];

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                          input logic [DATA_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_beat();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W/32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic bit is_bad(input logic [63:0] a, input logic [3:0] l);
    int unsigned off;
    off = 32'(a % 64'd4096);
    return ((a % 64'd64) != 64'd0) || (off + (32'(l) + 1) * 64 > 4096);
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic load_all(input bit pattern);
    for (int i = 0; i < DEPTH; i++) begin
      logic [DATA_W-1:0] d;
      d = pattern ? {64{8'(8'h11 * (i + 1))}} : rnd_beat();
      buf_we = 1; buf_idx = 4'(i); buf_wdata = d;
      ref_buf[i] = d;
      @(negedge clk);
    end
    buf_we = 0;
  endtask

  task automatic check_buf();
    for (int i = 0; i < DEPTH; i++) begin
      buf_idx = 4'(i);
      @(negedge clk);
      check_eq($sformatf("buf[%0d]", i), buf_rdata, ref_buf[i]);
    end
  endtask

  task automatic cmd_issue(input logic [63:0] a, input logic [3:0] l, input logic [5:0] id,
                           input bit wr, input bit rd);
    check_eq("cmd_ready", 512'(cmd_ready), 512'(1));
    cmd_wr = wr; cmd_rd = rd; cmd_addr = a; cmd_len = l; cmd_id = id;
    @(negedge clk);
    cmd_wr = 0; cmd_rd = 0;
  endtask

  task automatic finish_cmd(input bit exp_err, input logic [4:0] exp_mis);
    check_eq("done", 512'(done), 512'(1));
    check_eq("err", 512'(err), 512'(exp_err));
    check_eq("mis_cnt", 512'(mis_cnt), 512'(exp_mis));
    @(negedge clk);
    check_eq("done_pulse", 512'(done), 512'(0));
    check_eq("ready_again", 512'(cmd_ready), 512'(1));
    check_eq("err_sticky", 512'(err), 512'(exp_err));
  endtask

  task automatic bad_tail();
    check_eq("bad_awvalid", 512'(awvalid), 512'(0));
    check_eq("bad_arvalid", 512'(arvalid), 512'(0));
    finish_cmd(1'b1, 5'd0);
  endtask

  task automatic do_write(input logic [63:0] a, input logic [3:0] l, input logic [1:0] br,
                          input bit stall, input bit also_rd);
    logic [5:0] id;
    int n, k;
    id = 6'($urandom());
    cmd_issue(a, l, id, 1'b1, also_rd);
    if (is_bad(a, l)) begin bad_tail(); return; end
    check_eq("err_clr", 512'(err), 512'(0));
    n = 0;
    while (!awvalid && n < 20) begin
      check_eq("w_before_aw", 512'(wvalid), 512'(0));
      @(negedge clk); n++;
    end
    check_eq("aw_latency", 512'(n), 512'(0));
    check_eq("awaddr", 512'(awaddr), 512'(a));
    check_eq("awlen", 512'(awlen), 512'(l));
    check_eq("awsize", 512'(awsize), 512'(6));
    check_eq("awid", 512'(awid), 512'(id));
    check_eq("wvalid_in_wa", 512'(wvalid), 512'(0));
    awready = 1;
    k = 0; n = 0;
    while (k <= int'(l) && n < 200) begin
      @(negedge clk); n++;
      awready = 0;
      wready = stall ? n[0] : 1'b1;
      // Loads while busy must not reach the buffer.
      buf_we = 1; buf_idx = 4'($urandom()); buf_wdata = '1;
      check_eq("ar_quiet", 512'(arvalid), 512'(0));
      if (wvalid && wready) begin
        check_eq($sformatf("wdata[%0d]", k), wdata, ref_buf[k]);
        check_eq($sformatf("wlast[%0d]", k), 512'(wlast), 512'(k == int'(l)));
        check_eq("wstrb", 512'(wstrb), {448'd0, {64{1'b1}}});
        k++;
      end
    end
    check_eq("w_beats", 512'(k), 512'(int'(l) + 1));
    @(negedge clk);
    wready = 0; buf_we = 0;
    n = 0;
    while (!bready && n < 20) begin @(negedge clk); n++; end
    check_eq("bready", 512'(bready), 512'(1));
    check_eq("wvalid_in_wb", 512'(wvalid), 512'(0));
    bvalid = 1; bresp = br; bid = 16'($urandom());
    @(negedge clk);
    bvalid = 0; bresp = 0;
    finish_cmd(br != 2'b00, 5'd0);
  endtask

  task automatic do_read(input logic [63:0] a, input logic [3:0] l, input int nb);
    logic [5:0] id;
    int n, mis;
    bit exp_err;
    id = 6'($urandom());
    cmd_issue(a, l, id, 1'b0, 1'b1);
    if (is_bad(a, l)) begin bad_tail(); return; end
    check_eq("err_clr", 512'(err), 512'(0));
    n = 0;
    while (!arvalid && n < 20) begin @(negedge clk); n++; end
    check_eq("ar_latency", 512'(n), 512'(0));
    check_eq("araddr", 512'(araddr), 512'(a));
    check_eq("arlen", 512'(arlen), 512'(l));
    check_eq("arsize", 512'(arsize), 512'(6));
    check_eq("arid", 512'(arid), 512'(id));
    check_eq("aw_quiet", 512'(awvalid), 512'(0));
    arready = 1;
    @(negedge clk);
    arready = 0;
    exp_err = 0; mis = 0;
    for (int b = 0; b < nb; b++) begin
      if ($urandom_range(2) == 0) begin rvalid = 0; @(negedge clk); end
      check_eq("rready", 512'(rready), 512'(1));
      rvalid = 1; rdata = rdat[b]; rresp = rrsp[b]; rlast = (b == nb - 1);
      rid = 16'($urandom());
      if (rrsp[b] != 2'b00) exp_err = 1;
      if (b < DEPTH) begin
`ifdef CL_PCIM_MSTR_RDCMP_EN
        if (rdat[b] != ref_buf[b] && mis < 16) mis++;
`else
        ref_buf[b] = rdat[b];
`endif
      end
      @(negedge clk);
    end
    rvalid = 0; rlast = 0; rresp = 0;
    if (nb - 1 != int'(l)) exp_err = 1;
    if (mis != 0) exp_err = 1;
    finish_cmd(exp_err, 5'(mis));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_awvalid", 512'(awvalid), 512'(0));
    check_eq("rst_wvalid", 512'(wvalid), 512'(0));
    check_eq("rst_arvalid", 512'(arvalid), 512'(0));
    check_eq("rst_readies", 512'({bready, rready}), 512'(0));
    check_eq("rst_done_err", 512'({done, err}), 512'(0));
    check_eq("rst_mis", 512'(mis_cnt), 512'(0));
    rst_n = 1;
    @(negedge clk);
    check_eq("rst_ready", 512'(cmd_ready), 512'(1));

    // Patterned write, then stalled full-length write.
    load_all(1'b1);
    do_write(64'h1000, 4'd3, 2'b00, 1'b0, 1'b0);
    load_all(1'b0);
    do_write(64'h3000, 4'd15, 2'b00, 1'b1, 1'b0);

    // Two-beat read.
    rdat[0] = {64{8'hAA}}; rdat[1] = {64{8'hBB}}; rrsp[0] = 0; rrsp[1] = 0;
    do_read(64'h2000, 4'd1, 2);
    check_buf();

    // Rejected commands, exact page end accepted, error response then clear.
    do_write(64'h0FC0, 4'd1, 2'b00, 1'b0, 1'b0);
    do_write(64'h1004, 4'd0, 2'b00, 1'b0, 1'b0);
    do_read(64'h7FC0, 4'd1, 2);
    do_write(64'h0FC0, 4'd0, 2'b00, 1'b0, 1'b0);
    do_write(64'h1000, 4'd2, 2'b10, 1'b0, 1'b0);
    do_write(64'h1000, 4'd2, 2'b00, 1'b0, 1'b0);
    // Simultaneous strobes: write wins.
    do_write(64'h6000, 4'd2, 2'b00, 1'b0, 1'b1);

    // Write a pattern, read it back with beat 2 corrupted.
    load_all(1'b0);
    do_write(64'h5000, 4'd3, 2'b00, 1'b0, 1'b0);
    for (int b = 0; b < 4; b++) begin rdat[b] = ref_buf[b]; rrsp[b] = 0; end
    rdat[2][0] = ~rdat[2][0];
    do_read(64'h5000, 4'd3, 4);
    check_buf();

    // Random commands, including short/long read bursts and error responses.
    for (int it = 0; it < 14; it++) begin
      logic [63:0] a;
      logic [3:0] l;
      int nb;
      a = {32'd0, $urandom()};
      a[5:0] = ($urandom_range(7) == 0) ? 6'($urandom()) : 6'd0;
      l = 4'($urandom());
      if ($urandom_range(1) == 1) begin
        do_write(a, l, ($urandom_range(3) == 0) ? 2'($urandom()) : 2'b00,
                 1'($urandom()), 1'b0);
      end else begin
        nb = ($urandom_range(3) == 0) ? $urandom_range(20, 1) : int'(l) + 1;
        for (int b = 0; b < 20; b++) begin
          rdat[b] = rnd_beat();
          rrsp[b] = ($urandom_range(5) == 0) ? 2'($urandom()) : 2'b00;
        end
        do_read(a, l, nb);
        check_buf();
      end
    end

    // Reset in the middle of a write data phase.
    load_all(1'b0);
    cmd_issue(64'h4000, 4'd7, 6'd5, 1'b1, 1'b0);
    awready = 1;
    @(negedge clk);
    awready = 0; wready = 1;
    check_eq("wd_wvalid", 512'(wvalid), 512'(1));
    @(negedge clk);
    rst_n = 0;
    #1;
    check_eq("rst_mid_wvalid", 512'(wvalid), 512'(0));
    check_eq("rst_mid_idle", 512'(cmd_ready), 512'(1));
    check_eq("rst_mid_done", 512'(done), 512'(0));
    wready = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check_eq("rst_mid_nodone", 512'(done), 512'(0));
    check_buf();
    do_write(64'h4000, 4'd7, 2'b00, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
